// File: rtl/xor_word_packer.sv
// rtl/xor_word_packer.sv - consistency check and MSB-first serial packing of replicated XOR words
module xor_word_packer #(
  parameter int PACK_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_word,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PACK_W-1:0]            out_data,
  output logic [$clog2(PACK_W+1)-1:0]  out_len,
  output logic [ERR_W-1:0]             err_cnt,
  output logic                         err_flag
);

  localparam int LW = $clog2(PACK_W+1);
  localparam logic [LW-1:0] LAST_IDX = LW'(PACK_W - 1);
  localparam logic [LW-1:0] FULL_LEN = LW'(PACK_W);

  logic [PACK_W-1:0] sr_q, sr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic [PACK_W-1:0] od_q, od_d;
  logic [LW-1:0]     ol_q, ol_d;
  logic [ERR_W-1:0]  ec_q, ec_d;
  logic              ef_q, ef_d;

  logic              accept;
  logic              drain;
  logic              consistent;
  logic              bit_acc;
  logic [PACK_W-1:0] sr_acc;
  logic [LW-1:0]     cnt_acc;
  logic [LW-1:0]     pad_shift;

  // The output register is free whenever it is empty or being drained, which is
  // also exactly when a new input word may be taken.
  assign in_ready   = !ov_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign drain      = ov_q && out_ready;
  assign consistent = (in_word == 4'h0) || (in_word == 4'hF);
  assign bit_acc    = accept && consistent;

  // Shift register and count as they stand after this cycle's accept; both the
  // full-frame load and the flush path build their frame from these.
  assign sr_acc    = bit_acc ? {sr_q[PACK_W-2:0], in_word[0]} : sr_q;
  assign cnt_acc   = bit_acc ? cnt_q + 1'b1 : cnt_q;
  assign pad_shift = FULL_LEN - cnt_acc;

  // Next-state: packing, frame load (full frame wins over flush), drain, error count
  always_comb begin
    sr_d  = sr_acc;
    cnt_d = cnt_acc;
    ov_d  = ov_q;
    od_d  = od_q;
    ol_d  = ol_q;
    ec_d  = ec_q;
    ef_d  = ef_q;

    if (drain) begin
      ov_d = 1'b0;
    end

    if (accept && !consistent) begin
      ef_d = 1'b1;
      if (ec_q != {ERR_W{1'b1}}) begin
        ec_d = ec_q + 1'b1;
      end
    end

    if (bit_acc && (cnt_q == LAST_IDX)) begin
      ov_d  = 1'b1;
      od_d  = sr_acc;
      ol_d  = FULL_LEN;
      cnt_d = '0;
    end else if (flush && (cnt_acc != '0) && in_ready) begin
      // Stale upper bits of the shift register fall off the top when the
      // partial frame is left-aligned.
      ov_d  = 1'b1;
      od_d  = sr_acc << pad_shift;
      ol_d  = cnt_acc;
      cnt_d = '0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      ol_q  <= '0;
      ec_q  <= '0;
      ef_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
      ol_q  <= ol_d;
      ec_q  <= ec_d;
      ef_q  <= ef_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_len   = ol_q;
  assign err_cnt   = ec_q;
  assign err_flag  = ef_q;

endmodule

// File: tb/tb_xor_word_packer.sv
// tb/tb_xor_word_packer.sv - scoreboard bench for xor_word_packer with a bit-queue reference model
module tb_xor_word_packer;

  localparam int PACK_W = 8;
  localparam int ERR_W  = 8;
  localparam int LW     = $clog2(PACK_W+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_word = 4'h0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PACK_W-1:0] out_data;
  logic [LW-1:0]     out_len;
  logic [ERR_W-1:0]  err_cnt;
  logic              err_flag;

  xor_word_packer #(.PACK_W(PACK_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_len(out_len),
    .err_cnt(err_cnt), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PACK_W-1:0] d;
    int                l;
  } frame_t;

  frame_t exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  // reference model state
  int     m_bits[$];
  bit     m_ov   = 0;
  int     m_err  = 0;
  bit     m_flag = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t make_frame();
    frame_t f;
    f.d = '0;
    f.l = m_bits.size();
    for (int i = 0; i < m_bits.size(); i++) f.d[PACK_W-1-i] = m_bits[i][0];
    return f;
  endfunction

  // monitor: pops and compares each frame as it is handed off, and checks hold stability
  bit                prev_hold = 0;
  logic [PACK_W-1:0] prev_d;
  logic [LW-1:0]     prev_l;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold <= 0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_d);
        check("hold_len", out_len, prev_l);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          check("frame_data", out_data, e.d);
          check("frame_len", out_len, e.l);
        end
      end
      prev_hold <= out_valid && !out_ready;
      prev_d    <= out_data;
      prev_l    <= out_len;
    end
  end

  // one cycle of stimulus; model evaluated at the negedge ahead of the next rising edge
  task automatic step(input bit v, input logic [3:0] w, input bit f, input bit ordy);
    bit rdy, acc, cons, nxt_ov;
    in_valid = v; in_word = w; flush = f; out_ready = ordy;
    @(negedge clk);
    rdy = !m_ov || ordy;
    check("out_valid", out_valid, m_ov);
    check("in_ready", in_ready, rdy);
    check("err_cnt", err_cnt, m_err);
    check("err_flag", err_flag, m_flag);
    acc    = v && rdy;
    cons   = (w == 4'h0) || (w == 4'hF);
    nxt_ov = (m_ov && ordy) ? 0 : m_ov;
    if (acc && cons) begin
      m_bits.push_back(int'(w[0]));
      if (m_bits.size() == PACK_W) begin
        exp_q.push_back(make_frame());
        m_bits.delete();
        nxt_ov = 1;
      end
    end else if (acc) begin
      m_flag = 1;
      if (m_err < (1 << ERR_W) - 1) m_err++;
    end
    if (f && m_bits.size() > 0 && rdy) begin
      exp_q.push_back(make_frame());
      m_bits.delete();
      nxt_ov = 1;
    end
    m_ov = nxt_ov;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_len", out_len, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_in_ready", in_ready, 1);
    m_bits.delete(); exp_q.delete();
    m_ov = 0; m_err = 0; m_flag = 0;
    rst = 0;
  endtask

  function automatic logic [3:0] rand_word(input bit cons);
    logic [3:0] w;
    if (cons) w = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
    else      w = 4'($urandom_range(1, 14));
    return w;
  endfunction

  initial begin
    logic [3:0] t1 [8] = '{4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    @(posedge clk); #1;
    do_reset();

    // 1: full frame F,0,F,F,0,0,F,0 -> B2
    for (int i = 0; i < 8; i++) step(1, t1[i], 0, 1);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 8'hB2);
    check("t1_len", out_len, 8);

    // 2: F,5,0 -> one error, two bits kept (1,0), flushed as 80/len 2
    step(1, 4'hF, 0, 1);
    step(1, 4'h5, 0, 1);
    step(1, 4'h0, 0, 1);
    check("t2_err_cnt", err_cnt, 1);
    check("t2_err_flag", err_flag, 1);
    step(0, 4'h0, 1, 1);
    check("t2_data", out_data, 8'h80);
    check("t2_len", out_len, 2);

    // 3: 1,1 then 0 with same-cycle flush -> C0/len 3; empty flush ignored
    step(1, 4'hF, 0, 1);
    step(1, 4'hF, 0, 1);
    step(1, 4'h0, 1, 1);
    check("t3_data", out_data, 8'hC0);
    check("t3_len", out_len, 3);
    step(0, 4'h0, 1, 1);
    step(0, 4'h0, 1, 1);
    check("t3_empty_flush", out_valid, 0);

    // 4: frame held with out_ready low stalls input; release accepts in the drain cycle
    for (int i = 0; i < 8; i++) step(1, rand_word(1), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4'hF, 1, 0);
    check("t4_in_ready", in_ready, 0);
    for (int i = 0; i < 8; i++) step(1, rand_word(1), 0, 1);
    step(0, 4'h0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, rand_word($urandom_range(0, 9) < 8),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    for (int i = 0; i < 3; i++) step(0, 4'h0, 0, 1);

    // 5: counter saturation, no frames from dropped words
    do_reset();
    for (int i = 0; i < 300; i++) step(1, rand_word(0), 0, 1);
    check("t5_err_cnt", err_cnt, 255);
    check("t5_no_frame", out_valid, 0);
    step(1, 4'h3, 0, 1);
    check("t5_err_hold", err_cnt, 255);

    // 6: reset with held frame, then reset at cnt=5; next frame needs 8 fresh bits
    for (int i = 0; i < 8; i++) step(1, rand_word(1), 0, 0);
    check("t6_held", out_valid, 1);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 4'hF, 0, 1);
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 4'h0, 0, 1);
    check("t6_not_yet", out_valid, 0);
    step(1, 4'hF, 0, 1);
    check("t6_data", out_data, 8'h01);
    check("t6_len", out_len, 8);
    for (int i = 0; i < 3; i++) step(0, 4'h0, 0, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
